// File: rtl/sd_block_responder_if.sv
// Block-transfer bus between the save/load initiator and the image-side responder.
//   sd_lba       : block address (initiator -> responder)
//   sd_rd/sd_wr  : read / write request levels (initiator -> responder)
//   sd_ack       : high for the whole block transfer (responder -> initiator)
//   sd_buff_addr : word index within the block (responder -> initiator)
//   sd_buff_dout : read data into the initiator buffer (responder -> initiator)
//   sd_buff_wr   : one-cycle write strobe into the initiator buffer
//   sd_buff_din  : initiator buffer data, one cycle after sd_buff_addr
interface sd_block_responder_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/sd_block_responder.sv
// Image-side responder for the sd block protocol: services 512-byte blocks as
// 256 16-bit words against a simple backing-store port and reports mounts.
//   clk_sys, reset_n      : clock, async active-low reset
//   sd (slave)            : block request / buffer bus
//   mount_req, readonly   : mount trigger (rising edge) and write-protect flag
//   img_mounted/_readonly/_size : mount status
//   mem_addr/rd/wr/din/dout/ready : backing store, mem_rd/mem_wr held until mem_ready
//   lba_err               : sticky out-of-range flag, cleared on the next request
module sd_block_responder #(
  parameter int unsigned IMG_BLOCKS = 16,
  parameter int unsigned ACK_DELAY  = 4,
  parameter int unsigned MEM_AW     = 12
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  sd_block_responder_if.slave sd,
  input  logic              mount_req,
  input  logic              readonly,
  output logic              img_mounted,
  output logic              img_readonly,
  output logic [63:0]       img_size,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  input  logic              mem_ready,
  output logic              lba_err
);

  localparam int unsigned LBA_W   = 32;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned CNT_W   = 8;
  localparam logic [LBA_W-1:0] LBA_LIMIT = LBA_W'(IMG_BLOCKS);
  localparam logic [CNT_W:0]   ACK_DLY   = (CNT_W+1)'(ACK_DELAY);
  localparam logic [IDX_W-1:0] IDX_LAST  = '1;
  localparam logic [63:0]      IMG_BYTES = 64'(IMG_BLOCKS) * 64'd512;

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_RD_FETCH, S_RD_PUT,
    S_WR_ADDR, S_WR_SAMPLE, S_WR_STORE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LBA_W-1:0]  lba_q;
  logic              rd_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mount_q;

  logic in_range, store_en, delay_done, fetch_done, store_done, mount_rise, req;
  logic sd_ack_d, buff_wr_d, mem_rd_d, mem_wr_d;

  assign req        = sd.sd_rd | sd.sd_wr;
  assign in_range   = (lba_q < LBA_LIMIT);
  assign store_en   = in_range & ~img_readonly;
  assign delay_done = ({1'b0, cnt_q} + (CNT_W+1)'(1)) >= ACK_DLY;
  assign fetch_done = ~in_range | (mem_rd & mem_ready);
  assign store_done = ~store_en | (mem_wr & mem_ready);
  assign mount_rise = mount_req & ~mount_q;

  assign sd.sd_buff_addr = idx_q;
  assign mem_addr        = {lba_q[MEM_AW-9:0], idx_q};

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (req) state_d = S_DELAY;
      S_DELAY:     if (delay_done) state_d = rd_q ? S_RD_FETCH : S_WR_ADDR;
      S_RD_FETCH:  if (fetch_done) state_d = S_RD_PUT;
      S_RD_PUT:    state_d = (idx_q == IDX_LAST) ? S_DONE : S_RD_FETCH;
      S_WR_ADDR:   state_d = S_WR_SAMPLE;
      S_WR_SAMPLE: state_d = S_WR_STORE;
      S_WR_STORE:  if (store_done) state_d = (idx_q == IDX_LAST) ? S_DONE : S_WR_ADDR;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode on the upcoming state so the registered strobes line up with it
  always_comb begin
    sd_ack_d  = 1'b0;
    buff_wr_d = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    unique case (state_d)
      S_RD_FETCH: begin
        sd_ack_d = 1'b1;
        mem_rd_d = in_range;
      end
      S_RD_PUT: begin
        sd_ack_d  = 1'b1;
        buff_wr_d = 1'b1;
      end
      S_WR_ADDR, S_WR_SAMPLE: sd_ack_d = 1'b1;
      S_WR_STORE: begin
        sd_ack_d = 1'b1;
        mem_wr_d = store_en;
      end
      default: ;
    endcase
  end

  // Output registers and transfer datapath
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sd.sd_ack       <= 1'b0;
      sd.sd_buff_wr   <= 1'b0;
      sd.sd_buff_dout <= '0;
      mem_rd          <= 1'b0;
      mem_wr          <= 1'b0;
      mem_din         <= '0;
      lba_err         <= 1'b0;
      lba_q           <= '0;
      rd_q            <= 1'b0;
      idx_q           <= '0;
      cnt_q           <= '0;
    end else begin
      sd.sd_ack     <= sd_ack_d;
      sd.sd_buff_wr <= buff_wr_d;
      mem_rd        <= mem_rd_d;
      mem_wr        <= mem_wr_d;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            lba_q   <= sd.sd_lba;
            rd_q    <= sd.sd_rd;
            lba_err <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
          end
        end
        S_DELAY: cnt_q <= cnt_q + CNT_W'(1);
        S_RD_FETCH: begin
          if (!in_range) begin
            sd.sd_buff_dout <= 16'hFFFF;
            lba_err         <= 1'b1;
          end else if (mem_rd && mem_ready) begin
            sd.sd_buff_dout <= mem_dout;
          end
        end
        S_RD_PUT: if (idx_q != IDX_LAST) idx_q <= idx_q + IDX_W'(1);
        // Buffer data arrives one cycle after the address driven in S_WR_ADDR
        S_WR_SAMPLE: mem_din <= sd.sd_buff_din;
        S_WR_STORE: begin
          if (!in_range) lba_err <= 1'b1;
          if (store_done && idx_q != IDX_LAST) idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Mount tracking, independent of any transfer in flight
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mount_q      <= 1'b0;
      img_mounted  <= 1'b0;
      img_readonly <= 1'b0;
      img_size     <= '0;
    end else begin
      mount_q     <= mount_req;
      img_mounted <= mount_rise;
      if (mount_rise) begin
        img_readonly <= readonly;
        img_size     <= IMG_BYTES;
      end
    end
  end

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder with an initiator buffer model and a
// backing-store model (mem_ready one cycle after mem_rd / mem_wr).
module tb_sd_block_responder;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        mount_req, readonly;
  logic        img_mounted, img_readonly;
  logic [63:0] img_size;
  logic [11:0] mem_addr;
  logic        mem_rd, mem_wr, mem_ready;
  logic [15:0] mem_din, mem_dout;
  logic        lba_err;

  sd_block_responder_if sd_if();

  sd_block_responder #(.IMG_BLOCKS(16), .ACK_DELAY(4), .MEM_AW(12)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .sd           (sd_if.slave),
    .mount_req    (mount_req),
    .readonly     (readonly),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .mem_ready    (mem_ready),
    .lba_err      (lba_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Backing store: word a initially holds 16'(a), so block b word k = b*256+k
  logic [15:0] mem [0:4095];
  logic        fill;
  always @(posedge clk_sys) begin
    if (fill) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'(i);
    end else if (mem_wr && mem_ready) begin
      mem[mem_addr] <= mem_din;
    end
  end
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) mem_ready <= 1'b0;
    else          mem_ready <= (mem_rd | mem_wr) & ~mem_ready;
  end
  assign mem_dout = mem[mem_addr];

  // Initiator dual-port buffer with one-cycle read latency
  logic [15:0] dp [0:255];
  logic        dp_fill;
  always @(posedge clk_sys) begin
    if (dp_fill) begin
      for (int k = 0; k < 256; k++) dp[k] <= 16'hA5A5 ^ 16'(k);
    end else if (sd_if.sd_buff_wr) begin
      dp[sd_if.sd_buff_addr] <= sd_if.sd_buff_dout;
    end
    sd_if.sd_buff_din <= dp[sd_if.sd_buff_addr];
  end

  // Transfer monitor: strobe address/data against the expected sequence
  logic        mon_clr, mon_oor;
  logic [15:0] mon_base, exp_dout;
  int n_strobe, strobe_bad, n_memrd, n_memwr, n_rd_cyc, n_wr_cyc;
  assign exp_dout = mon_oor ? 16'hFFFF : 16'(mon_base + 16'(n_strobe));
  always @(posedge clk_sys) begin
    if (mon_clr) begin
      n_strobe <= 0; strobe_bad <= 0; n_memrd <= 0;
      n_memwr  <= 0; n_rd_cyc   <= 0; n_wr_cyc <= 0;
    end else begin
      if (sd_if.sd_buff_wr) begin
        if (sd_if.sd_buff_addr !== 8'(n_strobe) || sd_if.sd_buff_dout !== exp_dout)
          strobe_bad <= strobe_bad + 1;
        n_strobe <= n_strobe + 1;
      end
      if (mem_rd) n_rd_cyc <= n_rd_cyc + 1;
      if (mem_wr) n_wr_cyc <= n_wr_cyc + 1;
      if (mem_rd && mem_ready) n_memrd <= n_memrd + 1;
      if (mem_wr && mem_ready) n_memwr <= n_memwr + 1;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon(input logic [15:0] base, input logic oor);
    mon_base = base;
    mon_oor  = oor;
    mon_clr  = 1'b1;
    tick();
    mon_clr  = 1'b0;
  endtask

  task automatic wait_ack(input logic lvl, input int max, output int cyc);
    cyc = 0;
    while (sd_if.sd_ack !== lvl && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_mount(input logic ro);
    readonly  = ro;
    mount_req = 1'b1;
    tick();
    chk("mount_pulse", 64'(img_mounted), 64'd1);
    chk("mount_size", img_size, 64'd8192);
    chk("mount_ro", 64'(img_readonly), 64'(ro));
    tick();
    chk("mount_pulse_end", 64'(img_mounted), 64'd0);
    mount_req = 1'b0;
    tick();
  endtask

  // Issue one request, release the levels, time ack rise and ack high period
  task automatic run_block(input logic rd, input logic wr, input int lba,
                           output int rise_cyc, output int high_cyc);
    sd_if.sd_lba = 32'(lba);
    sd_if.sd_rd  = rd;
    sd_if.sd_wr  = wr;
    tick();
    sd_if.sd_rd = 1'b0;
    sd_if.sd_wr = 1'b0;
    wait_ack(1'b1, 20, rise_cyc);
    wait_ack(1'b0, 3000, high_cyc);
    tick();
  endtask

  initial begin
    int rc, hc, cyc, nblk, bad, r0, s0;
    reset_n = 1'b0; mount_req = 1'b0; readonly = 1'b0;
    fill = 1'b1; dp_fill = 1'b0; mon_clr = 1'b1; mon_oor = 1'b0; mon_base = '0;
    sd_if.sd_lba = '0; sd_if.sd_rd = 1'b0; sd_if.sd_wr = 1'b0;
    tick(); tick();
    fill = 1'b0; mon_clr = 1'b0;

    chk("rst_ack", 64'(sd_if.sd_ack), 64'd0);
    chk("rst_buff_wr", 64'(sd_if.sd_buff_wr), 64'd0);
    chk("rst_buff_addr", 64'(sd_if.sd_buff_addr), 64'd0);
    chk("rst_mem_rdwr", 64'({mem_rd, mem_wr}), 64'd0);
    chk("rst_img", 64'({img_mounted, img_readonly, lba_err}), 64'd0);
    chk("rst_size", img_size, 64'd0);
    reset_n = 1'b1;
    tick();

    do_mount(1'b0);

    // Read block 3
    clear_mon(16'h0300, 1'b0);
    run_block(1'b1, 1'b0, 3, rc, hc);
    chk("rd3_ack_rise", 64'(rc), 64'd4);
    chk("rd3_ack_high", 64'(hc), 64'd768);
    chk("rd3_strobes", 64'(n_strobe), 64'd256);
    chk("rd3_strobe_bad", 64'(strobe_bad), 64'd0);
    chk("rd3_memrd", 64'(n_memrd), 64'd256);
    chk("rd3_lba_err", 64'(lba_err), 64'd0);

    // Chained 16-block load, next request on each ack fall
    clear_mon(16'h0000, 1'b0);
    nblk = 0;
    sd_if.sd_lba = 32'd0;
    sd_if.sd_rd  = 1'b1;
    for (int b = 0; b < 16; b++) begin
      wait_ack(1'b1, 20, rc);
      wait_ack(1'b0, 3000, hc);
      if (rc < 20 && hc == 768) nblk++;
      if (b < 15) sd_if.sd_lba = 32'(b + 1);
      else        sd_if.sd_rd  = 1'b0;
    end
    for (int i = 0; i < 8; i++) tick();
    chk("chain_blocks", 64'(nblk), 64'd16);
    chk("chain_strobes", 64'(n_strobe), 64'd4096);
    chk("chain_strobe_bad", 64'(strobe_bad), 64'd0);
    chk("chain_memrd", 64'(n_memrd), 64'd4096);
    chk("chain_idle_ack", 64'(sd_if.sd_ack), 64'd0);

    // Write block 7 from the initiator buffer
    dp_fill = 1'b1;
    tick();
    dp_fill = 1'b0;
    clear_mon(16'h0000, 1'b0);
    run_block(1'b0, 1'b1, 7, rc, hc);
    chk("wr7_ack_rise", 64'(rc), 64'd4);
    chk("wr7_ack_high", 64'(hc), 64'd1024);
    chk("wr7_memwr", 64'(n_memwr), 64'd256);
    chk("wr7_strobes", 64'(n_strobe), 64'd0);
    chk("wr7_lba_err", 64'(lba_err), 64'd0);
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (mem[12'(7 * 256 + k)] !== (16'hA5A5 ^ 16'(k))) bad++;
    chk("wr7_mem_data", 64'(bad), 64'd0);

    // Out-of-range read
    clear_mon(16'h0000, 1'b1);
    run_block(1'b1, 1'b0, 16, rc, hc);
    chk("oor_ack_high", 64'(hc), 64'd512);
    chk("oor_strobes", 64'(n_strobe), 64'd256);
    chk("oor_strobe_bad", 64'(strobe_bad), 64'd0);
    chk("oor_lba_err", 64'(lba_err), 64'd1);
    chk("oor_no_memrd", 64'(n_rd_cyc), 64'd0);

    // Readonly mount, then a write that must not reach memory
    do_mount(1'b1);
    chk("ro_err_sticky", 64'(lba_err), 64'd1);
    clear_mon(16'h0000, 1'b0);
    run_block(1'b0, 1'b1, 5, rc, hc);
    chk("ro_ack_high", 64'(hc), 64'd768);
    chk("ro_no_memwr", 64'(n_wr_cyc), 64'd0);
    chk("ro_lba_err", 64'(lba_err), 64'd0);
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (mem[12'(5 * 256 + k)] !== 16'(16'h0500 + 16'(k))) bad++;
    chk("ro_mem_unchanged", 64'(bad), 64'd0);

    // Reset at word 100 of a read
    clear_mon(16'h0400, 1'b0);
    sd_if.sd_lba = 32'd4;
    sd_if.sd_rd  = 1'b1;
    tick();
    sd_if.sd_rd = 1'b0;
    cyc = 0;
    while (n_strobe < 100 && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("rstmid_reached", 64'(n_strobe), 64'd100);
    reset_n = 1'b0;
    #1;
    chk("rstmid_ack_drop", 64'(sd_if.sd_ack), 64'd0);
    chk("rstmid_mem_idle", 64'({mem_rd, mem_wr, sd_if.sd_buff_wr}), 64'd0);
    r0 = n_rd_cyc;
    s0 = n_strobe;
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("rstmid_no_access", 64'(n_rd_cyc), 64'(r0));
    chk("rstmid_no_strobe", 64'(n_strobe), 64'(s0));
    chk("rstmid_strobe_bad", 64'(strobe_bad), 64'd0);
    chk("rstmid_ack_low", 64'(sd_if.sd_ack), 64'd0);
    chk("rstmid_size_clr", img_size, 64'd0);

    // Fresh read of block 2 after reset
    clear_mon(16'h0200, 1'b0);
    run_block(1'b1, 1'b0, 2, rc, hc);
    chk("rd2_ack_rise", 64'(rc), 64'd4);
    chk("rd2_ack_high", 64'(hc), 64'd768);
    chk("rd2_strobes", 64'(n_strobe), 64'd256);
    chk("rd2_strobe_bad", 64'(strobe_bad), 64'd0);

    // Read and write together: read wins
    clear_mon(16'h0600, 1'b0);
    run_block(1'b1, 1'b1, 6, rc, hc);
    chk("both_ack_high", 64'(hc), 64'd768);
    chk("both_strobes", 64'(n_strobe), 64'd256);
    chk("both_strobe_bad", 64'(strobe_bad), 64'd0);
    chk("both_no_memwr", 64'(n_wr_cyc), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
- Implements the image-side (responder) end of the sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_* block protocol that the backup-RAM save/load logic initiates.
- Services 512-byte block transfers as 256 16-bit words against a simple backing-store memory port.
- Raises img_mounted / img_size / img_readonly on a mount request.
- Used as the on-FPGA virtual save device and as the bench model for save/load testing.

Parameters:
- IMG_BLOCKS, 16, number of 512-byte blocks in the image; valid LBAs are 0..IMG_BLOCKS-1.
- ACK_DELAY, 4, idle cycles between request acceptance and sd_ack rising (range 0..255).
- MEM_AW, 12, backing-store word-address width; must be at least log2(IMG_BLOCKS)+8.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sd_lba  in  32  block address from initiator.
- sd_rd  in  1  read request level (image -> initiator buffer).
- sd_wr  in  1  write request level (initiator buffer -> image).
- sd_ack  out  1  high for the entire block transfer.
- sd_buff_addr  out  8  word index within block.
- sd_buff_dout  out  16  read data to initiator buffer.
- sd_buff_wr  out  1  one-cycle write strobe into initiator buffer.
- sd_buff_din  in  16  initiator buffer data; valid 1 cycle after sd_buff_addr (dpram latency).
- mount_req  in  1  rising edge starts a mount.
- readonly  in  1  sampled at mount.
- img_mounted  out  1  one-cycle pulse.
- img_readonly  out  1  latched readonly.
- img_size  out  64  IMG_BLOCKS*512 after mount, else 0.
- mem_addr  out  MEM_AW  {lba, word index}.
- mem_rd  out  1  held until mem_ready.
- mem_wr  out  1  held until mem_ready.
- mem_din  out  16  write data.
- mem_dout  in  16  read data, valid with mem_ready.
- mem_ready  in  1  completes a mem_rd or mem_wr.
- lba_err  out  1  sticky; set on an out-of-range LBA; cleared on next accepted request.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, counters 0. Reset mid-transfer drops sd_ack immediately; the partial block is abandoned and no further memory access occurs.
- States: IDLE, DELAY, RD_FETCH, RD_PUT, WR_ADDR, WR_SAMPLE, WR_STORE, DONE.
- IDLE:
  - sd_rd high: accept a read. sd_wr high: accept a write. Both high: read wins.
  - On acceptance, latch sd_lba and direction, clear lba_err, go to DELAY.
  - Request levels are ignored outside IDLE.
- DELAY: count ACK_DELAY cycles, then set sd_ack=1. Word index = 0. Next state is RD_FETCH or WR_ADDR.
- RD_FETCH:
  - In range: assert mem_rd with mem_addr={lba,idx}; on mem_ready, latch mem_dout and go to RD_PUT.
  - Out of range (lba >= IMG_BLOCKS): no mem access, data = 16'hFFFF, set lba_err.
- RD_PUT: sd_buff_addr=idx, sd_buff_dout=data, sd_buff_wr=1 for exactly one cycle. If idx=255 go to DONE, else idx+1 and back to RD_FETCH.
- WR_ADDR: drive sd_buff_addr=idx for one cycle, then go to WR_SAMPLE.
- WR_SAMPLE: capture sd_buff_din into mem_din.
- WR_STORE:
  - Assert mem_wr until mem_ready.
  - Skip the memory write (no mem_wr) if img_readonly=1 or the LBA is out of range; out of range also sets lba_err.
  - If idx=255 go to DONE, else idx+1 and back to WR_ADDR.
- DONE: sd_ack=0, go to IDLE next cycle. The initiator's next request (e.g. lba+1, issued on the ack fall) is accepted from IDLE.
- sd_ack is held continuously high from DELAY end through the last word; exactly 256 buff strobes or samples per block.
- idx is 8 bits and never wraps within a block.
- LBA range compare uses the full 32 bits; mem_addr uses lba[MEM_AW-9:0].
- Mount:
  - A rising mount_req in any state latches readonly into img_readonly and sets img_size=IMG_BLOCKS*512.
  - img_mounted pulses 1 cycle, on the cycle after the edge.
  - A mount during a transfer does not disturb the transfer.
- Minimum read block time with mem_ready one cycle after mem_rd: ACK_DELAY + 256*3 + 1 cycles.

Test Plan:
- Mount with readonly=0 -> img_mounted single pulse, img_size=8192, img_readonly=0.
- Preload mem block 3 word k = 16'h0300+k; request sd_rd with sd_lba=3 -> sd_ack rises after 4 cycles; 256 sd_buff_wr strobes with addr 0..255, data 16'h0300..16'h03FF; ack falls; back to IDLE.
- Initiator-model dpram holds 16'hA5A5^k; request sd_wr with sd_lba=7 -> mem block 7 matches, confirming the 1-cycle din latency; 256 mem_wr; lba_err=0.
- Chained 16-block load (lba 0..15, next request issued on ack fall) -> all 16 blocks accepted; no missed or duplicated request; 4096 strobes.
- sd_lba=16 read -> all data 16'hFFFF, lba_err=1, no mem_rd. Readonly mount followed by a write -> no mem_wr, memory unchanged.
- Assert reset_n=0 at word 100 of a read -> sd_ack=0 immediately; after release a new sd_rd lba=2 completes normally. sd_rd and sd_wr both high -> read is performed.
